// File: rtl/mul_pipe_ctrl.sv
// Valid-bit and bank-strobe controller for the five-stage multiplier pipeline,
// including MUL5-priority arbitration of the shared ROB writeback port.
module mul_pipe_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic       rob_wb_ready,
    input  logic       alu_wb_req,
    output logic       alu_wb_grant,
    output logic       mul_wb_valid,
    output logic [4:0] bank_load,
    output logic [4:0] bank_reset,
    output logic [4:0] stage_valid,
    output logic [2:0] inflight,
    output logic       busy
);

    logic [4:0] v;
    logic [2:0] cnt;
    logic       kill;
    logic       ret5;
    logic       fire;
    logic       adv1, adv2, adv3, adv4, adv5;
    logic [4:0] adv;

    always_comb begin
        kill = reset | flush;
        ret5 = v[4] & rob_wb_ready & ~kill;
        // Each stage moves when it is empty or its successor moves, so bubbles collapse.
        adv5 = ~v[4] | ret5;
        adv4 = ~v[3] | adv5;
        adv3 = ~v[2] | adv4;
        adv2 = ~v[1] | adv3;
        adv1 = ~v[0] | adv2;
        adv  = {adv5, adv4, adv3, adv2, adv1};

        issue_ready  = adv1 & ~kill;
        fire         = issue_valid & issue_ready;
        mul_wb_valid = ret5;
        alu_wb_grant = alu_wb_req & rob_wb_ready & ~v[4] & ~kill;

        bank_load  = 5'b00000;
        bank_reset = 5'b11111;
        if (!kill) begin
            bank_load       = adv;
            // A bank loaded from an empty source is cleared so idle stages carry zero data.
            bank_reset[0]   = adv1 & ~fire;
            bank_reset[4:1] = adv[4:1] & ~v[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v   <= 5'b00000;
            cnt <= 3'd0;
        end else begin
            if (adv1) begin
                v[0] <= fire;
            end
            for (int k = 1; k < 5; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                end
            end
            case ({fire, ret5})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign stage_valid = v;
    assign inflight    = cnt;
    assign busy        = (cnt != 3'd0);

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl with a scoreboard of in-flight multiplies.
module tb_mul_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       issue_valid;
    logic       issue_ready;
    logic       rob_wb_ready;
    logic       alu_wb_req;
    logic       alu_wb_grant;
    logic       mul_wb_valid;
    logic [4:0] bank_load;
    logic [4:0] bank_reset;
    logic [4:0] stage_valid;
    logic [2:0] inflight;
    logic       busy;

    int total;
    int bad;
    int nid;
    int q[$];

    mul_pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .rob_wb_ready (rob_wb_ready),
        .alu_wb_req   (alu_wb_req),
        .alu_wb_grant (alu_wb_grant),
        .mul_wb_valid (mul_wb_valid),
        .bank_load    (bank_load),
        .bank_reset   (bank_reset),
        .stage_valid  (stage_valid),
        .inflight     (inflight),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled before the falling edge.
    task automatic drive(input logic iv, input logic rr, input logic ar,
                         input logic fl, input logic rs);
        issue_valid  = iv;
        rob_wb_ready = rr;
        alu_wb_req   = ar;
        flush        = fl;
        reset        = rs;
        #3;
    endtask

    task automatic tick();
        logic kl;
        kl = reset | flush;
        chk("wb_exclusive", {31'd0, mul_wb_valid & alu_wb_grant}, 32'd0);
        if (!kl) begin
            if (mul_wb_valid) begin
                chk("wb_pending", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) void'(q.pop_front());
            end
            if (issue_valid && issue_ready) begin
                q.push_back(nid);
                nid++;
            end
        end
        @(posedge clk);
        #1;
        if (kl) q.delete();
        chk("inflight_sb", {29'd0, inflight}, q.size());
        chk("popcount_sb", $countones(stage_valid), q.size());
    endtask

    initial begin
        logic [4:0] e;
        int guard;
        total = 0;
        bad   = 0;
        nid   = 0;
        reset = 1'b1;
        flush = 1'b0;
        issue_valid  = 1'b0;
        rob_wb_ready = 1'b0;
        alu_wb_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset forces strobes and handshakes
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
        chk("rst_bank_reset", {27'd0, bank_reset}, 32'h1f);
        chk("rst_bank_load", {27'd0, bank_load}, 32'h0);
        chk("rst_alu_grant", {31'd0, alu_wb_grant}, 32'd0);
        tick();
        chk("rst_stage_valid", {27'd0, stage_valid}, 32'h0);
        chk("rst_inflight", {29'd0, inflight}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("idle_bank_load", {27'd0, bank_load}, 32'h1f);
        chk("idle_bank_reset", {27'd0, bank_reset}, 32'h1f);
        tick();

        // single op walks the pipe and retires five cycles after issue
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_bank_reset", {27'd0, bank_reset}, 32'h1e);
        tick();
        chk("t1_sv0", {27'd0, stage_valid}, 32'h01);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t1_no_wb", {31'd0, mul_wb_valid}, 32'd0);
            tick();
            e = 5'b00001 << i;
            chk("t1_walk", {27'd0, stage_valid}, {27'd0, e});
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_wb", {31'd0, mul_wb_valid}, 32'd1);
        tick();
        chk("t1_empty", {27'd0, stage_valid}, 32'h0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // five back-to-back issues fill the stalled pipe
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t2_ready_fill", {31'd0, issue_ready}, 32'd1);
            tick();
        end
        chk("t2_full", {27'd0, stage_valid}, 32'h1f);
        chk("t2_inflight5", {29'd0, inflight}, 32'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_ready_full", {31'd0, issue_ready}, 32'd0);
        chk("t2_load_full", {27'd0, bank_load}, 32'h0);
        tick();
        chk("t2_frozen", {27'd0, stage_valid}, 32'h1f);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ready_ret", {31'd0, issue_ready}, 32'd1);
        chk("t2_wb_ret", {31'd0, mul_wb_valid}, 32'd1);
        chk("t2_load_ret", {27'd0, bank_load}, 32'h1f);
        chk("t2_breset_ret", {27'd0, bank_reset}, 32'h0);
        tick();
        chk("t2_inflight_same", {29'd0, inflight}, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2_drain_wb", {31'd0, mul_wb_valid}, 32'd1);
            tick();
            e = 5'b11111 << i;
            chk("t2_drain_sv", {27'd0, stage_valid}, {27'd0, e});
        end

        // holes collapse while MUL5 is stalled
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("t3_sv_10101", {27'd0, stage_valid}, 32'h15);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_load_a", {27'd0, bank_load}, 32'h0f);
        chk("t3_breset_a", {27'd0, bank_reset}, 32'h05);
        tick();
        chk("t3_sv_11010", {27'd0, stage_valid}, 32'h1a);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_load_b", {27'd0, bank_load}, 32'h07);
        chk("t3_breset_b", {27'd0, bank_reset}, 32'h03);
        tick();
        chk("t3_sv_11100", {27'd0, stage_valid}, 32'h1c);
        guard = 0;
        while (stage_valid != 5'b00000 && guard < 10) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            guard++;
        end
        chk("t3_drained", {27'd0, stage_valid}, 32'h0);

        // MUL5 beats a continuous ALU request
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_grant_issue", {31'd0, alu_wb_grant}, 32'd1);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("t4_grant_walk", {31'd0, alu_wb_grant}, 32'd1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_grant_blocked", {31'd0, alu_wb_grant}, 32'd0);
        chk("t4_mul_wb", {31'd0, mul_wb_valid}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_grant_after", {31'd0, alu_wb_grant}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_grant_no_rob", {31'd0, alu_wb_grant}, 32'd0);
        tick();

        // flush with v=10110 and a concurrent issue
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("t5_sv_10110", {27'd0, stage_valid}, 32'h16);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_ready", {31'd0, issue_ready}, 32'd0);
        chk("t5_breset", {27'd0, bank_reset}, 32'h1f);
        chk("t5_load", {27'd0, bank_load}, 32'h0);
        chk("t5_mul_wb", {31'd0, mul_wb_valid}, 32'd0);
        chk("t5_grant", {31'd0, alu_wb_grant}, 32'd0);
        tick();
        chk("t5_sv", {27'd0, stage_valid}, 32'h0);
        chk("t5_inflight", {29'd0, inflight}, 32'd0);

        // reset together with flush while the pipe is full
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("t6_full", {27'd0, stage_valid}, 32'h1f);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_ready", {31'd0, issue_ready}, 32'd0);
        chk("t6_mul_wb", {31'd0, mul_wb_valid}, 32'd0);
        chk("t6_grant", {31'd0, alu_wb_grant}, 32'd0);
        chk("t6_breset", {27'd0, bank_reset}, 32'h1f);
        chk("t6_load", {27'd0, bank_load}, 32'h0);
        tick();
        chk("t6_sv", {27'd0, stage_valid}, 32'h0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_ready_hold", {31'd0, issue_ready}, 32'd0);
        tick();
        chk("t6_sv_hold", {27'd0, stage_valid}, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_ready_release", {31'd0, issue_ready}, 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
